// File: rtl/dual_xor_cfg_sequencer.sv
// Configuration sequencer for the dual-XOR stream cipher: serially loads the LFSR
// taps/seeds into the cipher config chain, reads them back for checking, then enables TX/RX.
module dual_xor_cfg_sequencer #(
  parameter int unsigned M = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         config_once,
  input  logic [M-1:0] tx_lfsr_taps,
  input  logic [M-1:0] tx_lfsr_state,
  input  logic [M-1:0] rx_lfsr_taps,
  input  logic [M-1:0] rx_lfsr_state,
  input  logic         cfg_i,
  output logic         cfg_en,
  output logic         cfg_o,
  output logic         tx_en,
  output logic         rx_en,
  output logic         busy,
  output logic         done,
  output logic         cfg_error,
  output logic [7:0]   mismatch_cnt
);

  localparam int unsigned L  = 4 * M;
  localparam int unsigned CW = $clog2(L);
  localparam int unsigned MW = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_VERIFY,
    S_RUN,
    S_ERROR
  } state_t;

  state_t         state_q, state_d;
  logic [L-1:0]   sh_q, sh_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [MW-1:0]  mis_q, mis_d;
  logic           err_q, err_d;
  logic           configured_q, configured_d;
  logic           done_q, done_d;
  logic           cfg_en_q, cfg_en_d;
  logic           cfg_o_q, cfg_o_d;
  logic           run_en_q, run_en_d;
  logic           busy_q, busy_d;
  logic           bit_err;
  logic           last_bit;

  // State and datapath registers; reset returns everything to a clean IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      sh_q         <= '0;
      cnt_q        <= '0;
      mis_q        <= '0;
      err_q        <= 1'b0;
      configured_q <= 1'b0;
      done_q       <= 1'b0;
      cfg_en_q     <= 1'b0;
      cfg_o_q      <= 1'b0;
      run_en_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sh_q         <= sh_d;
      cnt_q        <= cnt_d;
      mis_q        <= mis_d;
      err_q        <= err_d;
      configured_q <= configured_d;
      done_q       <= done_d;
      cfg_en_q     <= cfg_en_d;
      cfg_o_q      <= cfg_o_d;
      run_en_q     <= run_en_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sh_d         = sh_q;
    cnt_d        = cnt_q;
    mis_d        = mis_q;
    err_d        = err_q;
    configured_d = configured_q;
    done_d       = 1'b0;
    // cfg_o_q always mirrors sh_q[L-1] while shifting, so it is the bit the chain tail must echo
    bit_err      = cfg_i ^ cfg_o_q;
    last_bit     = (cnt_q == CW'(L - 1));

    unique case (state_q)
      S_IDLE, S_RUN, S_ERROR: begin
        if (start && !(config_once && configured_q)) begin
          state_d = S_LOAD;
          sh_d    = {tx_lfsr_taps, tx_lfsr_state, rx_lfsr_taps, rx_lfsr_state};
          cnt_d   = '0;
          mis_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        sh_d = {sh_q[L-2:0], sh_q[L-1]};
        if (last_bit) begin
          state_d = S_VERIFY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_VERIFY: begin
        sh_d = {sh_q[L-2:0], sh_q[L-1]};
        if (bit_err && (mis_q != {MW{1'b1}})) begin
          mis_d = mis_q + MW'(1);
        end
        if (last_bit) begin
          cnt_d = '0;
          if ((mis_q == '0) && !bit_err) begin
            state_d      = S_RUN;
            done_d       = 1'b1;
            configured_d = 1'b1;
          end else begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    cfg_en_d = (state_d == S_LOAD) || (state_d == S_VERIFY);
    busy_d   = cfg_en_d;
    cfg_o_d  = cfg_en_d ? sh_d[L-1] : 1'b0;
    // Enables rise one cycle after entering RUN and drop as soon as a reload is accepted
    run_en_d = (state_q == S_RUN) && (state_d == S_RUN);
  end

  assign cfg_en       = cfg_en_q;
  assign cfg_o        = cfg_o_q;
  assign tx_en        = run_en_q;
  assign rx_en        = run_en_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign cfg_error    = err_q;
  assign mismatch_cnt = mis_q;

endmodule

// File: tb/tb_dual_xor_cfg_sequencer.sv
// Bench for dual_xor_cfg_sequencer: loopback config chain, randomized LFSR words,
// directed load/verify/error/config_once/reset scenarios.
module tb_dual_xor_cfg_sequencer;

  localparam int unsigned M = 32;
  localparam int unsigned L = 4 * M;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         config_once = 1'b0;
  logic [M-1:0] tx_lfsr_taps = '0;
  logic [M-1:0] tx_lfsr_state = '0;
  logic [M-1:0] rx_lfsr_taps = '0;
  logic [M-1:0] rx_lfsr_state = '0;
  logic         cfg_i;
  logic         cfg_en, cfg_o, tx_en, rx_en, busy, done, cfg_error;
  logic [7:0]   mismatch_cnt;

  logic [L-1:0] chain = '0;
  logic         inject = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dual_xor_cfg_sequencer #(.M(M)) dut (
    .clk(clk), .rst(rst), .start(start), .config_once(config_once),
    .tx_lfsr_taps(tx_lfsr_taps), .tx_lfsr_state(tx_lfsr_state),
    .rx_lfsr_taps(rx_lfsr_taps), .rx_lfsr_state(rx_lfsr_state),
    .cfg_i(cfg_i), .cfg_en(cfg_en), .cfg_o(cfg_o), .tx_en(tx_en), .rx_en(rx_en),
    .busy(busy), .done(done), .cfg_error(cfg_error), .mismatch_cnt(mismatch_cnt)
  );

  // Loopback cipher model: an L-bit shift chain whose tail feeds back, with optional bit flips
  always @(posedge clk) if (cfg_en) chain <= {chain[L-2:0], cfg_o};
  assign cfg_i = chain[L-1] ^ inject;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_cfg_en"}, 32'(cfg_en), 32'd0);
    chk({tag, "_cfg_o"}, 32'(cfg_o), 32'd0);
    chk({tag, "_tx_en"}, 32'(tx_en), 32'd0);
    chk({tag, "_rx_en"}, 32'(rx_en), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_cfg_error"}, 32'(cfg_error), 32'd0);
    chk({tag, "_mismatch"}, 32'(mismatch_cnt), 32'd0);
  endtask

  // One full configuration attempt starting from an accepting state; n_inj VERIFY bits are flipped.
  task automatic do_config(input string tag, input logic [M-1:0] tt, input logic [M-1:0] ts,
                           input logic [M-1:0] rt, input logic [M-1:0] rs,
                           input int n_inj, input bit hold);
    logic [L-1:0] vec;
    bit           inj_at[L];
    int           placed;
    int           p;
    int           exp_mis;
    vec = {tt, ts, rt, rs};
    foreach (inj_at[k]) inj_at[k] = 1'b0;
    placed = 0;
    while (placed < n_inj) begin
      p = int'($urandom_range(L - 1, 0));
      if (!inj_at[p]) begin
        inj_at[p] = 1'b1;
        placed++;
      end
    end
    exp_mis = (n_inj > 255) ? 255 : n_inj;

    @(negedge clk);
    tx_lfsr_taps = tt; tx_lfsr_state = ts; rx_lfsr_taps = rt; rx_lfsr_state = rs;
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    // Scramble the snapshot inputs: the shadow must already hold the captured words
    tx_lfsr_taps = $urandom; tx_lfsr_state = $urandom;
    rx_lfsr_taps = $urandom; rx_lfsr_state = $urandom;

    for (int i = 0; i < 2 * L; i++) begin
      inject = (i >= L) ? inj_at[i - L] : 1'b0;
      chk({tag, "_cfg_en"}, 32'(cfg_en), 32'd1);
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_tx_en"}, 32'(tx_en), 32'd0);
      chk({tag, "_done_early"}, 32'(done), 32'd0);
      chk({tag, "_cfg_o"}, 32'(cfg_o), 32'(vec[L - 1 - (i % L)]));
      @(negedge clk);
    end
    inject = 1'b0;

    chk({tag, "_cfg_en_end"}, 32'(cfg_en), 32'd0);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_tx_en_end"}, 32'(tx_en), 32'd0);
    chk({tag, "_done"}, 32'(done), (n_inj == 0) ? 32'd1 : 32'd0);
    chk({tag, "_cfg_error"}, 32'(cfg_error), (n_inj == 0) ? 32'd0 : 32'd1);
    chk({tag, "_mismatch"}, 32'(mismatch_cnt), 32'(exp_mis));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_tx_en_run"}, 32'(tx_en), (n_inj == 0) ? 32'd1 : 32'd0);
    chk({tag, "_rx_en_run"}, 32'(rx_en), (n_inj == 0) ? 32'd1 : 32'd0);
    chk({tag, "_cfg_en_run"}, 32'(cfg_en), 32'd0);
    chk({tag, "_cfg_o_run"}, 32'(cfg_o), 32'd0);
    chk({tag, "_cfg_error_hold"}, 32'(cfg_error), (n_inj == 0) ? 32'd0 : 32'd1);
  endtask

  initial begin
    int n;
    // Reset state
    #12;
    chk_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_idle_outputs("idle");

    // Basic configuration with the reference words, then random words
    do_config("basic", 32'h48000000, 32'h55, 32'h48000000, 32'h55, 0, 1'b0);
    do_config("rand1", $urandom, $urandom, $urandom, $urandom, 0, 1'b0);

    // Fault injection: 3 flipped readback bits, then a random count, then a clean retry
    do_config("inj3", $urandom, $urandom, $urandom, $urandom, 3, 1'b0);
    n = int'($urandom_range(40, 1));
    do_config("injr", $urandom, $urandom, $urandom, $urandom, n, 1'b0);
    do_config("inj_all", $urandom, $urandom, $urandom, $urandom, L, 1'b0);
    do_config("retry", $urandom, $urandom, $urandom, $urandom, 0, 1'b0);

    // config_once: start in RUN must be ignored once configured
    config_once = 1'b1;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("once_tx_en", 32'(tx_en), 32'd1);
      chk("once_cfg_en", 32'(cfg_en), 32'd0);
      chk("once_busy", 32'(busy), 32'd0);
    end
    start = 1'b0;
    config_once = 1'b0;
    do_config("reconf", $urandom, $urandom, $urandom, $urandom, 0, 1'b0);

    // Reset in the middle of LOAD
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    chk("midload_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk_idle_outputs("midload_rst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_idle_outputs("post_rst");
    do_config("after_rst", $urandom, $urandom, $urandom, $urandom, 0, 1'b0);

    // Start held high throughout: exactly one sequence, then stays in RUN
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    config_once = 1'b1;
    do_config("hold", $urandom, $urandom, $urandom, $urandom, 0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_tx_en", 32'(tx_en), 32'd1);
      chk("hold_cfg_en", 32'(cfg_en), 32'd0);
      chk("hold_done", 32'(done), 32'd0);
    end
    start = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
